// File: rtl/ascon_sequencer_if.sv
// ascon_sequencer_if: upstream plaintext stream and downstream ciphertext stream
interface ascon_sequencer_if;
  logic [63:0] pt_data_i;
  logic        pt_valid_i;
  logic        pt_last_i;
  logic        pt_ready_o;
  logic [63:0] ct_data_o;
  logic        ct_valid_o;
  logic        ct_ready_i;
  modport slave (
    input  pt_data_i, pt_valid_i, pt_last_i, ct_ready_i,
    output pt_ready_o, ct_data_o, ct_valid_o
  );
  modport master (
    output pt_data_i, pt_valid_i, pt_last_i, ct_ready_i,
    input  pt_ready_o, ct_data_o, ct_valid_o
  );
endinterface

// File: rtl/ascon_sequencer.sv
// ascon_sequencer: walks one ascon core through init, one AD block, N PT blocks and finalisation
module ascon_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [127:0]      key_i,
  input  logic [127:0]      nonce_i,
  input  logic [63:0]       ad_i,
  ascon_sequencer_if.slave  s,
  output logic [127:0]      tag_o,
  output logic              tag_valid_o,
  output logic              busy_o,
  output logic              error_o,
  output logic [CNT_W-1:0]  blk_cnt_o,
  output logic              core_init_o,
  output logic              core_associate_data_o,
  output logic              core_finalisation_o,
  output logic [63:0]       core_data_o,
  output logic              core_data_valid_o,
  output logic [127:0]      core_key_o,
  output logic [127:0]      core_nonce_o,
  input  logic              core_end_initialisation_i,
  input  logic              core_end_associate_i,
  input  logic              core_cipher_valid_i,
  input  logic              core_end_cipher_i,
  input  logic              core_end_tag_i,
  input  logic [63:0]       core_cipher_i,
  input  logic [127:0]      core_tag_i
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
  typedef enum logic [3:0] {IDLE, INIT, AD, PT_IN, PT_RUN, FINAL, DRAIN, DONE, ERR} state_t;
  state_t st;
  logic [127:0] key_r;
  logic [63:0] ad_r;
  logic last_r;
  logic [WD_W-1:0] wd;
  logic timed, leave, ct_free, hs;
  always_comb begin
    timed = st inside {INIT, AD, PT_RUN, FINAL};
    leave = st == INIT ? core_end_initialisation_i :
            st == AD ? core_end_associate_i :
            st == PT_RUN ? (last_r ? core_cipher_valid_i : core_end_cipher_i) :
            st == FINAL ? core_end_tag_i : 1'b0;
    ct_free = !s.ct_valid_o || s.ct_ready_i;
    hs = st == PT_IN && s.pt_valid_i && s.pt_ready_o;
  end
  // DRAIN holds off DONE until the CT buffer empties; it is untimed because only downstream can stall it
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st <= IDLE;
      key_r <= '0;
      ad_r <= '0;
      last_r <= 1'b0;
      wd <= '0;
      s.pt_ready_o <= 1'b0;
      s.ct_data_o <= '0;
      s.ct_valid_o <= 1'b0;
      tag_o <= '0;
      tag_valid_o <= 1'b0;
      busy_o <= 1'b0;
      error_o <= 1'b0;
      blk_cnt_o <= '0;
      core_init_o <= 1'b0;
      core_associate_data_o <= 1'b0;
      core_finalisation_o <= 1'b0;
      core_data_o <= '0;
      core_data_valid_o <= 1'b0;
      core_key_o <= '0;
      core_nonce_o <= '0;
    end else begin
      wd <= timed && !leave ? wd + 1'b1 : '0;
      if (s.ct_valid_o && s.ct_ready_i) s.ct_valid_o <= 1'b0;
      case (st)
        IDLE, DONE: if (start_i) begin
          st <= INIT;
          key_r <= key_i;
          ad_r <= ad_i;
          blk_cnt_o <= '0;
          tag_valid_o <= 1'b0;
          busy_o <= 1'b1;
          core_init_o <= 1'b1;
          core_key_o <= key_i;
          core_nonce_o <= nonce_i;
        end
        INIT: if (core_end_initialisation_i) begin
          st <= AD;
          core_init_o <= 1'b0;
          core_key_o <= '0;
          core_nonce_o <= '0;
          core_associate_data_o <= 1'b1;
          core_data_valid_o <= 1'b1;
          core_data_o <= ad_r;
        end
        AD: if (core_end_associate_i) begin
          st <= PT_IN;
          core_associate_data_o <= 1'b0;
          core_data_valid_o <= 1'b0;
          s.pt_ready_o <= ct_free;
        end
        PT_IN: if (hs) begin
          st <= PT_RUN;
          s.pt_ready_o <= 1'b0;
          last_r <= s.pt_last_i;
          core_data_o <= s.pt_data_i;
          core_data_valid_o <= 1'b1;
          if (~&blk_cnt_o) blk_cnt_o <= blk_cnt_o + 1'b1;
        end else s.pt_ready_o <= ct_free;
        PT_RUN: begin
          if (core_cipher_valid_i) begin
            s.ct_data_o <= core_cipher_i;
            s.ct_valid_o <= 1'b1;
          end
          if (last_r) begin
            core_data_valid_o <= 1'b0;
            if (core_cipher_valid_i) begin
              st <= FINAL;
              core_finalisation_o <= 1'b1;
              core_key_o <= key_r;
            end
          end else if (core_end_cipher_i) begin
            st <= PT_IN;
            core_data_valid_o <= 1'b0;
            s.pt_ready_o <= ct_free && !core_cipher_valid_i;
          end
        end
        FINAL: if (core_end_tag_i) begin
          st <= ct_free ? DONE : DRAIN;
          busy_o <= !ct_free;
          tag_o <= core_tag_i;
          tag_valid_o <= 1'b1;
          core_finalisation_o <= 1'b0;
          core_key_o <= '0;
        end
        DRAIN: if (ct_free) begin
          st <= DONE;
          busy_o <= 1'b0;
        end
        default: ;
      endcase
      if (timed && !leave && wd == WD_MAX) begin
        st <= ERR;
        error_o <= 1'b1;
        busy_o <= 1'b0;
        s.pt_ready_o <= 1'b0;
        core_init_o <= 1'b0;
        core_associate_data_o <= 1'b0;
        core_finalisation_o <= 1'b0;
        core_data_o <= '0;
        core_data_valid_o <= 1'b0;
        core_key_o <= '0;
        core_nonce_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ascon_sequencer.sv
// tb_ascon_sequencer: random messages through the sequencer against a stub core and a message-level model
module tb_ascon_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start;
  logic [127:0] key_in, nonce_in;
  logic [63:0] ad_in;
  logic [127:0] tag;
  logic tag_valid, busy, error;
  logic [7:0] blk_cnt;
  logic core_init, core_assoc, core_fin, core_dv;
  logic [63:0] core_data;
  logic [127:0] core_key, core_nonce;
  logic e_init, e_assoc, c_valid, e_cipher, e_tag;
  logic [63:0] cipher;
  logic [127:0] ctag;
  logic hang;
  int checks = 0, errors = 0;
  int dv_cycles = 0, fin_cycles = 0;
  ascon_sequencer_if sif();
  ascon_sequencer dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .key_i(key_in), .nonce_i(nonce_in), .ad_i(ad_in),
    .s(sif), .tag_o(tag), .tag_valid_o(tag_valid), .busy_o(busy), .error_o(error), .blk_cnt_o(blk_cnt),
    .core_init_o(core_init), .core_associate_data_o(core_assoc), .core_finalisation_o(core_fin),
    .core_data_o(core_data), .core_data_valid_o(core_dv), .core_key_o(core_key), .core_nonce_o(core_nonce),
    .core_end_initialisation_i(e_init), .core_end_associate_i(e_assoc), .core_cipher_valid_i(c_valid),
    .core_end_cipher_i(e_cipher), .core_end_tag_i(e_tag), .core_cipher_i(cipher), .core_tag_i(ctag)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (core_dv && !core_assoc) dv_cycles++;
    if (core_fin) fin_cycles++;
  end
  // stub core: answers each level-held request after a random latency
  initial begin
    int ph, lat, kind, sidx;
    logic [127:0] sk, sn;
    logic [63:0] sa, sd, sacc;
    ph = 0; lat = 0; kind = 0; sidx = 0;
    sk = '0; sn = '0; sa = '0; sd = '0; sacc = '0;
    {e_init, e_assoc, c_valid, e_cipher, e_tag} = '0;
    cipher = '0; ctag = '0;
    forever begin
      @(negedge clk);
      {e_init, e_assoc, c_valid, e_cipher, e_tag} = '0;
      if (rst) ph = 0;
      else if (ph == 2) begin e_cipher = 1'b1; ph = 0; end
      else if (ph == 0) begin
        kind = core_init ? (hang ? 0 : 1) : core_assoc ? 2 : core_dv ? 3 : core_fin ? 4 : 0;
        if (kind != 0) begin
          lat = $urandom_range(0, 3);
          ph = 1;
          if (kind == 1) begin sk = core_key; sn = core_nonce; sidx = 0; sacc = '0; end
          if (kind == 2) sa = core_data;
          if (kind == 3) sd = core_data;
        end
      end
      if (ph == 1) begin
        if (lat == 0) begin
          case (kind)
            1: e_init = 1'b1;
            2: e_assoc = 1'b1;
            3: begin
              c_valid = 1'b1;
              cipher = sd ^ sk[63:0] ^ sn[127:64] ^ sa ^ {sidx, 32'hC0FFEE00};
              sidx++;
              sacc ^= sd;
            end
            default: begin
              e_tag = 1'b1;
              ctag = {core_key[127:64] ^ sacc, sn[63:0] ^ 64'(sidx)};
            end
          endcase
          ph = kind == 3 ? 2 : 0;
        end else lat--;
      end
    end
  end
  task automatic run_msg(input int n, input int mode, input bit start_ad, input int rst_at, input bit fixed);
    logic [63:0] pt[$];
    logic [63:0] exp_ct[$];
    logic [127:0] k, nn, exp_tag;
    logic [63:0] a, acc;
    int beats, dv0, fin0, bw;
    bit abort;
    k = fixed ? 128'h8A55114D1CB6A9A2BE263D4D7AECAAFF : {$urandom, $urandom, $urandom, $urandom};
    nn = fixed ? 128'h4ED0EC0B98C529B7C8CDDF37BCD0284A : {$urandom, $urandom, $urandom, $urandom};
    a = fixed ? 64'h4120746F20428000 : {$urandom, $urandom};
    acc = '0;
    for (int i = 0; i < n; i++) begin
      pt.push_back({$urandom, $urandom});
      exp_ct.push_back(pt[i] ^ k[63:0] ^ nn[127:64] ^ a ^ {i, 32'hC0FFEE00});
      acc ^= pt[i];
    end
    exp_tag = {k[127:64] ^ acc, nn[63:0] ^ 64'(n)};
    @(negedge clk);
    key_in = k; nonce_in = nn; ad_in = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    nonce_in = {$urandom, $urandom, $urandom, $urandom};
    ad_in = {$urandom, $urandom};
    check("start_init", core_init, 1);
    check("start_tag_clr", tag_valid, 0);
    check("start_cnt", blk_cnt, 0);
    check("start_busy", busy, 1);
    check("start_key", core_key, k);
    check("start_nonce", core_nonce, nn);
    dv0 = dv_cycles; fin0 = fin_cycles;
    abort = 0; beats = 0;
    fork
      begin : feed
        for (int i = 0; i < n && !abort; i++) begin
          int bf;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          sif.pt_valid_i = 1'b1; sif.pt_data_i = pt[i]; sif.pt_last_i = i == n - 1;
          bf = 0;
          while (!sif.pt_ready_o && bf < 2000) begin @(negedge clk); bf++; end
          if (bf >= 2000) begin check("pt_timeout", 1, 0); abort = 1; end
          @(negedge clk);
          sif.pt_valid_i = 1'b0; sif.pt_last_i = 1'($urandom); sif.pt_data_i = {$urandom, $urandom};
          if (i + 1 == rst_at) begin
            check("rst_pre_dv", core_dv, 1);
            check("rst_pre_cnt", blk_cnt, 8'(rst_at));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_mid_ctl", {busy, tag_valid, error, core_init, core_assoc, core_fin, core_dv,
                                  sif.pt_ready_o, sif.ct_valid_o, blk_cnt}, 0);
            check("rst_mid_data", {core_data, sif.ct_data_o}, 0);
            check("rst_mid_key", core_key | core_nonce | tag, 0);
            abort = 1;
          end
        end
      end
      begin : sink
        int bs, idle;
        bit stalled;
        logic [63:0] held;
        idle = 0; stalled = 0;
        while (beats < n && !abort && idle < 20 * n + 400) begin
          if (mode == 2 && beats == 5 && !stalled) begin
            stalled = 1;
            sif.ct_ready_i = 1'b0;
            bs = 0;
            while (!sif.ct_valid_o && bs < 200) begin @(negedge clk); bs++; end
            held = sif.ct_data_o;
            repeat (10) begin
              @(negedge clk);
              check("stall_data", sif.ct_data_o, held);
              check("stall_valid", sif.ct_valid_o, 1);
              check("stall_pt_ready", sif.pt_ready_o, 0);
            end
          end
          sif.ct_ready_i = mode == 1 ? $urandom_range(0, 3) != 0 : 1'b1;
          if (sif.ct_valid_o && sif.ct_ready_i) begin
            check($sformatf("ct%0d", beats), sif.ct_data_o, exp_ct[beats]);
            beats++;
          end
          @(negedge clk);
          idle++;
        end
        sif.ct_ready_i = 1'b1;
      end
      begin : ad_start
        if (start_ad) begin
          int ba;
          ba = 0;
          while (!core_assoc && ba < 200) begin @(negedge clk); ba++; end
          check("ad_reached", core_assoc, 1);
          key_in = ~k; start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          check("ad_start_init", core_init, 0);
          check("ad_start_busy", busy, 1);
        end
      end
    join
    if (!abort) begin
      bw = 0;
      while (!(tag_valid && !busy) && bw < 20 * n + 400) begin @(negedge clk); bw++; end
      check("done_reached", tag_valid && !busy, 1);
      check("beats", beats, n);
      check("tag", tag, exp_tag);
      check("blk_cnt", blk_cnt, n > 255 ? 255 : n);
      check("done_err", error, 0);
      check("done_ct_empty", sif.ct_valid_o, 0);
      if (n == 1) begin
        check("single_dv_cycles", dv_cycles - dv0, 1);
        check("single_fin_seen", fin_cycles != fin0, 1);
      end
    end
  endtask
  initial begin
    int c;
    hang = 1'b0; start = 1'b0;
    key_in = '0; nonce_in = '0; ad_in = '0;
    sif.pt_valid_i = 1'b0; sif.pt_last_i = 1'b0; sif.pt_data_i = '0; sif.ct_ready_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctl", {busy, tag_valid, error, core_init, core_assoc, core_fin, core_dv,
                        sif.pt_ready_o, sif.ct_valid_o, blk_cnt}, 0);
    check("reset_data", {core_data, sif.ct_data_o}, 0);
    check("reset_key", core_key | core_nonce | tag, 0);
    rst = 1'b0;
    @(negedge clk);
    run_msg(23, 0, 0, 0, 1);
    run_msg(23, 2, 0, 0, 1);
    run_msg(1, 0, 0, 0, 0);
    run_msg(8, 1, 1, 0, 0);
    repeat (4) run_msg($urandom_range(1, 12), 1, 0, 0, 0);
    run_msg(300, 0, 0, 0, 0);
    run_msg(23, 0, 0, 7, 1);
    run_msg(23, 0, 0, 0, 1);
    hang = 1'b1;
    @(negedge clk);
    key_in = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wd_init", core_init, 1);
    c = 0;
    while (!error && c < 1000) begin @(negedge clk); c++; end
    check("wd_cycles", c, 255);
    check("wd_error", error, 1);
    check("wd_core_ctl", {core_init, core_assoc, core_fin, core_dv, busy, sif.pt_ready_o}, 0);
    check("wd_core_bus", core_key | core_nonce | {64'd0, core_data}, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("err_start_ign", core_init, 0);
    check("err_sticky", error, 1);
    hang = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("err_cleared", error, 0);
    run_msg(5, 1, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
